// File: rtl/cfg_commit_pkg.sv
// cfg_commit_pkg: shared widths, CRC polynomial and FSM states for the config commit block
package cfg_commit_pkg;
  localparam int CTRL_W = 192;
  localparam int CRC_W = 8;
  localparam int FRAME_LEN = CTRL_W + CRC_W;
  localparam logic [7:0] CRC_POLY = 8'h07;
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
endpackage

// File: rtl/crc8_serial.sv
// crc8_serial: one-bit MSB-first CRC-8 update step
module crc8_serial
  import cfg_commit_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic       bit_in,
  output logic [7:0] crc_out
);
  always_comb crc_out = {crc_in[6:0], 1'b0} ^ ((crc_in[7] ^ bit_in) ? CRC_POLY : 8'h00);
endmodule

// File: rtl/cfg_commit.sv
// cfg_commit: serial config frame receiver; applies the control word only for full frames with a clean CRC
module cfg_commit #(
  parameter int CTRL_W = cfg_commit_pkg::CTRL_W,
  parameter int CRC_W = cfg_commit_pkg::CRC_W,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              data_in,
  output logic              data_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              cfg_ok,
  output logic              cfg_err
);
  import cfg_commit_pkg::*;
  localparam int FL = CTRL_W + CRC_W;
  state_t state;
  logic [FL-1:0] sr;
  logic [CNT_W-1:0] cnt;
  logic [7:0] crc, crc_nxt;
  // a new frame restarts the CRC from zero in the same cycle it shifts its first bit
  crc8_serial u_crc (
    .crc_in (state == IDLE ? 8'h00 : crc),
    .bit_in (data_in),
    .crc_out(crc_nxt)
  );
  assign data_out = sr[FL-1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      crc      <= '0;
      ctrl_out <= '0;
      cfg_ok   <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_ok <= 1'b0;
      case (state)
        IDLE: if (enable) begin
          sr      <= {sr[FL-2:0], data_in};
          crc     <= crc_nxt;
          cnt     <= CNT_W'(1);
          cfg_err <= 1'b0;
          state   <= SHIFT;
        end
        SHIFT: if (enable) begin
          sr  <= {sr[FL-2:0], data_in};
          crc <= crc_nxt;
          cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
        end else state <= CHECK;
        CHECK: begin
          state <= IDLE;
          if (cnt == CNT_W'(FL) && crc == 8'h00) begin
            ctrl_out <= sr[FL-1:CRC_W];
            cfg_ok   <= 1'b1;
          end else cfg_err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cfg_commit.sv
// tb_cfg_commit: directed self-checking bench for cfg_commit
module tb_cfg_commit;
  logic clk = 1'b0, rst_n = 1'b1, enable = 1'b0, data_in = 1'b0;
  logic data_out, cfg_ok, cfg_err;
  logic [191:0] ctrl_out, ctrl1, ctrl2;
  logic ok1, ok2, ok3;
  int checks = 0, errors = 0;

  cfg_commit dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .data_in(data_in),
    .data_out(data_out), .ctrl_out(ctrl_out), .cfg_ok(cfg_ok), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] crc8(input logic [191:0] d);
    logic [7:0] c = 8'h00;
    for (int i = 191; i >= 0; i--) c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? 8'h07 : 8'h00);
    return c;
  endfunction

  function automatic logic [199:0] frame(input logic [7:0] p);
    logic [191:0] d;
    d = {24{p}};
    return {d, crc8(d)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [255:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      enable = 1'b1;
      data_in = v[i];
      tick();
    end
  endtask

  task automatic close();
    enable = 1'b0;
    data_in = 1'b0;
    tick();
    ok1 = cfg_ok;
    ctrl1 = ctrl_out;
    tick();
    ok2 = cfg_ok;
    ctrl2 = ctrl_out;
    tick();
    ok3 = cfg_ok;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    checks += 4;
    if (ctrl_out !== '0) begin errors++; $display("FAIL reset_ctrl got %h exp 0", ctrl_out); end
    if (cfg_ok !== 1'b0) begin errors++; $display("FAIL reset_ok got %b exp 0", cfg_ok); end
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", cfg_err); end
    if (data_out !== 1'b0) begin errors++; $display("FAIL reset_dout got %b exp 0", data_out); end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_valid();
    shift_bits(256'(frame(8'hA5)), 200);
    close();
    checks += 5;
    if (ctrl1 !== '0) begin errors++; $display("FAIL valid_ctrl_early got %h exp 0", ctrl1); end
    if (ctrl2 !== {24{8'hA5}}) begin errors++; $display("FAIL valid_ctrl got %h exp %h", ctrl2, {24{8'hA5}}); end
    if (ok2 !== 1'b1) begin errors++; $display("FAIL valid_ok got %b exp 1", ok2); end
    if ({ok1, ok3} !== 2'b00) begin errors++; $display("FAIL valid_ok_once got %b%b exp 00", ok1, ok3); end
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL valid_err got %b exp 0", cfg_err); end
  endtask

  task automatic test_bad_crc();
    shift_bits(256'(frame(8'hA5) ^ 200'd1), 200);
    close();
    checks += 3;
    if (ctrl_out !== {24{8'hA5}}) begin errors++; $display("FAIL badcrc_ctrl got %h exp %h", ctrl_out, {24{8'hA5}}); end
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL badcrc_err got %b exp 1", cfg_err); end
    if ({ok1, ok2, ok3} !== 3'b000) begin errors++; $display("FAIL badcrc_ok got %b%b%b exp 000", ok1, ok2, ok3); end
  endtask

  task automatic test_length();
    logic [199:0] f;
    f = frame(8'hA5);
    shift_bits(256'(f[199:1]), 199);
    close();
    checks += 2;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL len199_err got %b exp 1", cfg_err); end
    if (ok2 !== 1'b0) begin errors++; $display("FAIL len199_ok got %b exp 0", ok2); end
    shift_bits(256'({f, 1'b0}), 201);
    close();
    checks += 3;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL len201_err got %b exp 1", cfg_err); end
    if (ok2 !== 1'b0) begin errors++; $display("FAIL len201_ok got %b exp 0", ok2); end
    if (ctrl_out !== {24{8'hA5}}) begin errors++; $display("FAIL len201_ctrl got %h exp %h", ctrl_out, {24{8'hA5}}); end
    shift_bits(256'(frame(8'h3C)), 200);
    close();
    checks += 3;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL len_recover_err got %b exp 0", cfg_err); end
    if (ok2 !== 1'b1) begin errors++; $display("FAIL len_recover_ok got %b exp 1", ok2); end
    if (ctrl2 !== {24{8'h3C}}) begin errors++; $display("FAIL len_recover_ctrl got %h exp %h", ctrl2, {24{8'h3C}}); end
  endtask

  task automatic test_reset_mid();
    logic [199:0] f;
    f = frame(8'h5A);
    shift_bits(256'(f[199:100]), 100);
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (ctrl_out !== '0) begin errors++; $display("FAIL rstmid_ctrl got %h exp 0", ctrl_out); end
    if (data_out !== 1'b0) begin errors++; $display("FAIL rstmid_dout got %b exp 0", data_out); end
    if (cfg_ok !== 1'b0) begin errors++; $display("FAIL rstmid_ok got %b exp 0", cfg_ok); end
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL rstmid_err got %b exp 0", cfg_err); end
    enable = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    shift_bits(256'(f), 200);
    close();
    checks += 2;
    if (ctrl2 !== {24{8'h5A}}) begin errors++; $display("FAIL rstmid_apply got %h exp %h", ctrl2, {24{8'h5A}}); end
    if (ok2 !== 1'b1) begin errors++; $display("FAIL rstmid_apply_ok got %b exp 1", ok2); end
  endtask

  task automatic test_readback();
    logic pat [400];
    for (int i = 0; i < 400; i++) pat[i] = ^(32'(i) * 32'd37 + 32'd11);
    for (int i = 0; i < 400; i++) begin
      enable = 1'b1;
      data_in = pat[i];
      if (i >= 200) begin
        checks++;
        if (data_out !== pat[i-200]) begin errors++; $display("FAIL readback_%0d got %b exp %b", i, data_out, pat[i-200]); end
      end
      tick();
    end
    close();
    checks += 2;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL readback_err got %b exp 1", cfg_err); end
    if (ctrl_out !== {24{8'h5A}}) begin errors++; $display("FAIL readback_ctrl got %h exp %h", ctrl_out, {24{8'h5A}}); end
  endtask

  task automatic test_check_enable();
    shift_bits(256'(frame(8'hC3)), 200);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    data_in = 1'b1;
    tick();
    checks += 2;
    if (cfg_ok !== 1'b1) begin errors++; $display("FAIL chken_ok got %b exp 1", cfg_ok); end
    if (ctrl_out !== {24{8'hC3}}) begin errors++; $display("FAIL chken_ctrl got %h exp %h", ctrl_out, {24{8'hC3}}); end
    shift_bits(256'(frame(8'h81)), 200);
    close();
    checks += 3;
    if (ctrl2 !== {24{8'h81}}) begin errors++; $display("FAIL chken_next_ctrl got %h exp %h", ctrl2, {24{8'h81}}); end
    if (ok2 !== 1'b1) begin errors++; $display("FAIL chken_next_ok got %b exp 1", ok2); end
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL chken_next_err got %b exp 0", cfg_err); end
  endtask

  initial begin
    test_reset();
    test_valid();
    test_bad_crc();
    test_length();
    test_reset_mid();
    test_readback();
    test_check_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cfg_commit.md
CFG_COMMIT -- requirements
Module: cfg_commit

Interface
REQ-001 SHALL have parameter CTRL_W, default 192, meaning the width of the applied analog control word.
REQ-002 SHALL have parameter CRC_W, default 8, meaning the width of the CRC trailer appended to each frame.
REQ-003 SHALL have parameter CNT_W, default 8, meaning the width of the saturating bit counter (must hold CTRL_W+CRC_W+1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port enable, input, 1 bit: frame strobe; the block shifts while it is high.
REQ-007 SHALL have port data_in, input, 1 bit: serial frame bit, sampled on the rising edge of clk when enable=1.
REQ-008 SHALL have port data_out, output, 1 bit: chain readback, equal to the MSB of the shift register.
REQ-009 SHALL have port ctrl_out, output, CTRL_W bits: the applied control word fed to the analog switch matrix.
REQ-010 SHALL have port cfg_ok, output, 1 bit: one-cycle pulse, asserted when a frame is applied.
REQ-011 SHALL have port cfg_err, output, 1 bit: sticky flag for a rejected frame.

Function
REQ-012 SHALL hold a shift register sr of CTRL_W+CRC_W (200) bits and an FSM with states IDLE, SHIFT and CHECK.
REQ-013 In IDLE, enable=1 SHALL clear the CRC and counter, clear cfg_err, shift in the first bit, and enter SHIFT in the same cycle.
REQ-014 In SHIFT with enable=1, each cycle SHALL perform sr <= {sr[198:0], data_in}, advance the CRC, and increment the counter, saturating at 2^CNT_W-1.
REQ-015 The CRC SHALL be CRC-8, polynomial 0x07, init 0x00, MSB-first, no reflection and no xorout, computed over all received bits including the trailer.
REQ-016 In SHIFT, the first cycle sampling enable=0 SHALL enter CHECK and SHALL NOT shift.
REQ-017 In CHECK, a frame SHALL be accepted when the count is exactly 200 and the CRC residue is 0x00.
REQ-018 On acceptance, ctrl_out SHALL take sr[199:8] on the edge leaving CHECK, so the first-received bit lands in ctrl_out[191], and cfg_ok SHALL pulse in that same cycle.
REQ-019 On rejection (count ≠ 200 or residue ≠ 0), ctrl_out SHALL hold its previous value and cfg_err SHALL be set.
REQ-020 CHECK SHALL always return to IDLE after one cycle; an enable=1 seen in CHECK SHALL be ignored, and a new frame starts no earlier than the following cycle in IDLE.
REQ-021 data_out SHALL be sr[199] and SHALL be registered, with no combinational path from data_in.
REQ-022 ctrl_out SHALL never change except per REQ-018; partial frames and glitches on enable SHALL leave it untouched.

Reset
REQ-023 rst_n=0 SHALL asynchronously force state IDLE, sr=0, counter=0, CRC=0, ctrl_out=0 (all switches open), cfg_ok=0, cfg_err=0, data_out=0.
REQ-024 Reset asserted mid-frame SHALL discard the frame; after release, the block SHALL require a complete new frame.

Structure
REQ-025 A shared package SHALL hold CTRL_W, CRC_W, FRAME_LEN=200, CRC_POLY=8'h07, and the FSM state enumeration.
REQ-026 The one-bit CRC-8 update SHALL be a separate combinational sub-module, crc8_serial.

Verification
REQ-027 The bench SHALL shift 192 data bits 0xA5 repeating plus the matching CRC, then drop enable -> ctrl_out=0xA5..A5 two edges after enable falls, cfg_ok pulses once, and cfg_err=0.
REQ-028 The bench SHALL send the same frame with its last CRC bit flipped -> ctrl_out is unchanged from the previous value and cfg_err=1.
REQ-029 The bench SHALL send frames of 199 bits and of 201 bits with valid-looking data -> both are rejected and cfg_err=1; a following valid frame clears cfg_err and is applied.
REQ-030 The bench SHALL assert rst_n low after 100 bits of a frame -> all outputs are 0 immediately; a next full valid frame is applied correctly.
REQ-031 The bench SHALL shift 400 bits with a known pattern -> data_out reproduces data_in delayed by exactly 200 cycles.
REQ-032 The bench SHALL reassert enable during the CHECK cycle -> the bit is ignored and the next frame starts cleanly from IDLE.
